// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller for the memory stage of the pipelined core.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cpu_re/cpu_we/cpu_addr      memory-stage load/store request
//   cpu_wdata/cpu_be            store data and byte enables
//   cpu_rdata, stall            load data and pipeline hold (combinational)
//   flush                       invalidate all lines when idle with no request
//   mem_req/mem_we/mem_addr     word-wide main-memory request (combinational)
//   mem_wdata/mem_be            memory write data and byte enables
//   mem_ready/mem_rdata         memory beat accept and read data
//   hit_count/miss_count        saturating read-hit / read-miss counters
module dcache_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned SETS           = 16,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_re,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [3:0]            cpu_be,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  stall,
   input  logic                  flush,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int unsigned OB = $clog2(WORDS_PER_LINE);
   localparam int unsigned IB = $clog2(SETS);
   localparam int unsigned TW = ADDR_WIDTH - IB - OB - 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [OB-1:0]         beat_q, beat_d;
   logic [SETS-1:0]       valid_q;
   logic [TW-1:0]         tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

   logic [OB-1:0]         req_off_c;
   logic [IB-1:0]         req_idx_c;
   logic [TW-1:0]         req_tag_c;
   logic                  line_hit_c;
   logic [DATA_WIDTH-1:0] merged_c;

   logic hit_inc_c, miss_start_c, fill_wr_c, fill_done_c, store_merge_c, flush_all_c;

   // Byte offset bits never select anything; the word is the unit of access.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[1:0];

   // Address decode and tag compare for the current request.
   assign req_off_c  = cpu_addr[2 +: OB];
   assign req_idx_c  = cpu_addr[2 + OB +: IB];
   assign req_tag_c  = cpu_addr[ADDR_WIDTH-1 -: TW];
   assign line_hit_c = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);

   // Cached word with the enabled store bytes overlaid.
   always_comb begin
      merged_c = data_q[req_idx_c][req_off_c];
      for (int b = 0; b < 4; b++) begin
         if (cpu_be[b]) merged_c[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
   end

   // Next-state and output decode; everything forced quiet while in reset.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      stall         = 1'b0;
      cpu_rdata     = '0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_be        = '0;
      hit_inc_c     = 1'b0;
      miss_start_c  = 1'b0;
      fill_wr_c     = 1'b0;
      fill_done_c   = 1'b0;
      store_merge_c = 1'b0;
      flush_all_c   = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE: begin
               if (cpu_re) begin
                  if (line_hit_c) begin
                     cpu_rdata = data_q[req_idx_c][req_off_c];
                     hit_inc_c = 1'b1;
                  end else begin
                     stall        = 1'b1;
                     miss_start_c = 1'b1;
                     beat_d       = '0;
                     state_d      = ST_FILL;
                  end
               end else if (cpu_we) begin
                  stall   = 1'b1;
                  state_d = ST_WRITE;
               end else if (flush) begin
                  flush_all_c = 1'b1;
               end
            end
            ST_FILL: begin
               stall    = 1'b1;
               mem_req  = 1'b1;
               mem_addr = {req_tag_c, req_idx_c, beat_q, 2'b00};
               if (mem_ready) begin
                  fill_wr_c = 1'b1;
                  beat_d    = beat_q + OB'(1);
                  if (beat_q == OB'(WORDS_PER_LINE - 1)) begin
                     fill_done_c = 1'b1;
                     state_d     = ST_IDLE;
                  end
               end
            end
            ST_WRITE: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
               mem_wdata = cpu_wdata;
               mem_be    = cpu_be;
               stall     = !mem_ready;
               if (mem_ready) begin
                  store_merge_c = line_hit_c;
                  state_d       = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Control state, valid bits and counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         valid_q    <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (flush_all_c) valid_q <= '0;
         // The victim line is dropped as soon as its refill starts, so an
         // aborted fill can never leave a half-written line marked valid.
         if (miss_start_c) valid_q[req_idx_c] <= 1'b0;
         if (fill_done_c)  valid_q[req_idx_c] <= 1'b1;
         if (hit_inc_c && (hit_count != 32'hFFFF_FFFF))
            hit_count <= hit_count + 32'd1;
         if (miss_start_c && (miss_count != 32'hFFFF_FFFF))
            miss_count <= miss_count + 32'd1;
      end
   end

   // Tag and data storage; contents are qualified by valid_q.
   always_ff @(posedge clk) begin
      if (fill_done_c) tag_q[req_idx_c] <= req_tag_c;
      if (fill_wr_c)
         data_q[req_idx_c][beat_q] <= mem_rdata;
      else if (store_merge_c)
         data_q[req_idx_c][req_off_c] <= merged_c;
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a memory responder,
// a read-data scoreboard and an expected memory-transaction queue.
module tb_dcache_ctrl;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_txn_t;

   logic        clk;
   logic        rst_n;
   logic        cpu_re, cpu_we, flush;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_be;
   logic        stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count, miss_count;

   int errors = 0;
   int checks = 0;
   int exp_hits = 0;
   int exp_misses = 0;
   int ready_delay = 0;

   logic [31:0] tb_mem [logic [31:0]];
   logic [31:0] rd_q [$];
   mem_txn_t    exp_mem_q [$];

   dcache_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_be     (cpu_be),
      .cpu_rdata  (cpu_rdata),
      .stall      (stall),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Backing memory: written words, otherwise an address-derived pattern.
   function automatic logic [31:0] rd_model(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      if (tb_mem.exists(k)) return tb_mem[k];
      return {k[15:0] ^ 16'hC3A5, k[15:0]};
   endfunction

   // Memory responder: acts 1 time unit after each falling edge.
   logic        in_txn = 1'b0;
   int          wait_cnt = 0;
   logic [31:0] hold_addr, hold_wdata;
   logic [3:0]  hold_be;
   logic        hold_we;

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
   end

   always @(negedge clk) begin
      mem_txn_t    t;
      logic [31:0] w;
      #1;
      if (mem_req) begin
         if (in_txn) begin
            chk("hold_addr", mem_addr, hold_addr);
            chk("hold_wdata", mem_wdata, hold_wdata);
            chk("hold_be", {28'b0, mem_be}, {28'b0, hold_be});
            chk("hold_we", {31'b0, mem_we}, {31'b0, hold_we});
         end else begin
            in_txn     = 1'b1;
            wait_cnt   = 0;
            hold_addr  = mem_addr;
            hold_wdata = mem_wdata;
            hold_be    = mem_be;
            hold_we    = mem_we;
         end
         if (wait_cnt >= ready_delay) begin
            mem_ready = 1'b1;
            mem_rdata = rd_model(mem_addr);
            chk("mem_txn_expected", {31'b0, exp_mem_q.size() != 0}, 32'd1);
            if (exp_mem_q.size() != 0) begin
               t = exp_mem_q.pop_front();
               chk("mem_addr", mem_addr, t.addr);
               chk("mem_we", {31'b0, mem_we}, {31'b0, t.we});
               if (t.we) begin
                  chk("mem_wdata", mem_wdata, t.wdata);
                  chk("mem_be", {28'b0, mem_be}, {28'b0, t.be});
               end
            end
            if (mem_we) begin
               w = rd_model(mem_addr);
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
               tb_mem[{mem_addr[31:2], 2'b00}] = w;
            end
            in_txn = 1'b0;
         end else begin
            mem_ready = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ready = 1'b0;
         in_txn    = 1'b0;
      end
   end

   task automatic idle();
      @(negedge clk);
      cpu_re = 1'b0;
      cpu_we = 1'b0;
      flush  = 1'b0;
      #2;
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_hits"}, hit_count, 32'(exp_hits));
      chk({tag, "_misses"}, miss_count, 32'(exp_misses));
   endtask

   // Issue a load; exp_stalls is 0 for a hit, 1 + 4 beats for a zero-wait miss.
   task automatic do_load(input logic [31:0] addr, input int exp_stalls,
                          input logic fl, output logic [31:0] got);
      int          stalls;
      logic [31:0] base;
      mem_txn_t    t;
      @(negedge clk);
      ready_delay = 0;
      cpu_re   = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = addr;
      flush    = fl;
      rd_q.push_back(rd_model(addr));
      if (exp_stalls > 0) begin
         base = addr & ~32'hF;
         for (int i = 0; i < 4; i++) begin
            t = '{we: 1'b0, addr: base + 32'(4*i), wdata: 32'h0, be: 4'h0};
            exp_mem_q.push_back(t);
         end
         exp_misses++;
      end
      exp_hits++;
      stalls = 0;
      #2;
      while (stall && stalls <= 100) begin
         stalls++;
         @(negedge clk);
         #2;
      end
      chk("load_stalls", 32'(stalls), 32'(exp_stalls));
      if (exp_stalls == 0) chk("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
      got = cpu_rdata;
      chk("load_data", cpu_rdata, rd_q.pop_front());
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input int delay);
      int       stalls;
      mem_txn_t t;
      @(negedge clk);
      ready_delay = delay;
      cpu_re    = 1'b0;
      cpu_we    = 1'b1;
      cpu_addr  = addr;
      cpu_wdata = data;
      cpu_be    = be;
      flush     = 1'b0;
      t = '{we: 1'b1, addr: {addr[31:2], 2'b00}, wdata: data, be: be};
      exp_mem_q.push_back(t);
      stalls = 0;
      #2;
      while (stall && stalls <= 100) begin
         stalls++;
         @(negedge clk);
         #2;
      end
      chk("store_stalls", 32'(stalls), 32'(1 + delay));
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] orig;
      mem_txn_t    t;

      // Reset with a load already presented: outputs must stay quiet.
      rst_n = 1'b0;
      cpu_re = 1'b1; cpu_we = 1'b0; flush = 1'b0;
      cpu_addr = 32'h100; cpu_wdata = '0; cpu_be = '0;
      repeat (2) @(negedge clk);
      #2;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cpu_re = 1'b0;
      #2;
      check_counters("rst");

      // Cold miss on 0x100, then back-to-back hit on 0x104.
      do_load(32'h100, 5, 1'b0, got);
      do_load(32'h104, 0, 1'b0, got);
      idle();
      check_counters("fill_hit");

      // Partial store with a slow memory, then a hit with the merged word.
      orig = rd_model(32'h108);
      do_store(32'h108, 32'hDEAD_BEEF, 4'b0011, 3);
      do_load(32'h108, 0, 1'b0, got);
      chk("store_merge", got, {orig[31:16], 16'hBEEF});

      // Store miss does not allocate; the following load misses.
      do_store(32'h2000, 32'h1234_5678, 4'b1111, 1);
      do_load(32'h2000, 5, 1'b0, got);
      chk("store_then_load", got, 32'h1234_5678);

      // Conflicting tags on index 0 evict each other.
      do_load(32'h100, 5, 1'b0, got);
      do_load(32'h500, 5, 1'b0, got);
      do_load(32'h100, 5, 1'b0, got);
      idle();
      check_counters("conflict");

      // Reset during beat 2 of a fill on 0x340.
      @(negedge clk);
      ready_delay = 0;
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h340; flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         t = '{we: 1'b0, addr: 32'h340 + 32'(4*i), wdata: 32'h0, be: 4'h0};
         exp_mem_q.push_back(t);
      end
      #2;
      chk("abort_miss_stall", {31'b0, stall}, 32'd1);
      repeat (2) begin
         @(negedge clk);
         #2;
      end
      @(negedge clk);
      rst_n  = 1'b0;
      cpu_re = 1'b0;
      #2;
      chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
      chk("abort_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      exp_hits = 0;
      exp_misses = 0;
      check_counters("abort");
      chk("abort_beats_left", 32'(exp_mem_q.size()), 32'd0);
      exp_mem_q.delete();

      // Line is invalid after the abort; flush then drops the refilled line.
      do_load(32'h340, 5, 1'b0, got);
      do_load(32'h340, 0, 1'b0, got);
      @(negedge clk);
      cpu_re = 1'b0; cpu_we = 1'b0; flush = 1'b1;
      idle();
      do_load(32'h340, 5, 1'b0, got);
      // Flush alongside a request is ignored.
      do_load(32'h340, 0, 1'b1, got);
      do_load(32'h340, 0, 1'b0, got);
      idle();
      check_counters("flush");

      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
      chk("mem_q_empty", 32'(exp_mem_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
